// File: rtl/moonbase_pkg.sv
// Shared constants and bus payload types for the moonbase external bus block.
// MOONBASE_SPLIT_SPACE_EN selects 256-byte split code/data storage; otherwise 128 bytes aliased.
package moonbase_pkg;

    localparam int unsigned STROBE   = 7;
    localparam int unsigned CODE_SEL = 6;
    localparam int unsigned RAM_WR_N = 5;
    localparam int unsigned DEV_WR_N = 4;

    localparam int unsigned ADDR_W = 7;

`ifdef MOONBASE_SPLIT_SPACE_EN
    localparam int unsigned MEM_AW = ADDR_W + 1;
`else
    localparam int unsigned MEM_AW = ADDR_W;
`endif

    localparam int unsigned MEM_DEPTH = 32'(1) << MEM_AW;

    // Low seven bits of bus_out during a data cycle
    typedef struct packed {
        logic       code_sel;
        logic       ram_wr_n;
        logic       dev_wr_n;
        logic [3:0] nibble;
    } bus_data_t;

    function automatic bus_data_t decode_data(input logic [7:0] bus_byte);
        return bus_data_t'(bus_byte[ADDR_W-1:0]);
    endfunction

endpackage

// File: rtl/moonbase_ext_bus_if.sv
// CPU bus and program-loader signals between the CPU side (master) and the bus block (slave).
interface moonbase_ext_bus_if;

    logic [7:0] bus_out;
    logic [3:0] ram_data;
    logic [1:0] dev_data;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_addr;
    logic [7:0] load_data;

    modport master (
        output bus_out,
        output load_valid,
        output load_addr,
        output load_data,
        input  ram_data,
        input  dev_data,
        input  load_ready
    );

    modport slave (
        input  bus_out,
        input  load_valid,
        input  load_addr,
        input  load_data,
        output ram_data,
        output dev_data,
        output load_ready
    );

endinterface

// File: rtl/moonbase_nibble_ram.sv
// Byte storage with a CPU nibble read/write port and a loader byte-write port.
// The CPU port wins when both write in the same cycle; contents are never reset.
module moonbase_nibble_ram
    import moonbase_pkg::*;
(
    input  logic              clk,
    input  logic              cpu_we,
    input  logic [MEM_AW-1:0] cpu_addr,
    input  logic              cpu_lo,
    input  logic [3:0]        cpu_wdata,
    output logic [3:0]        cpu_rdata_c,
    input  logic              byte_we,
    input  logic [MEM_AW-1:0] byte_addr,
    input  logic [7:0]        byte_wdata
);

    logic [7:0]        mem_q [MEM_DEPTH];
    logic [7:0]        cpu_byte_c;
    logic              we_d;
    logic [MEM_AW-1:0] waddr_d;
    logic [7:0]        wdata_d;

    assign cpu_byte_c  = mem_q[cpu_addr];
    assign cpu_rdata_c = cpu_lo ? cpu_byte_c[3:0] : cpu_byte_c[7:4];

    // Nibble writes merge with the untouched half of the current byte
    always_comb begin
        we_d    = 1'b0;
        waddr_d = byte_addr;
        wdata_d = byte_wdata;
        if (cpu_we) begin
            we_d    = 1'b1;
            waddr_d = cpu_addr;
            wdata_d = cpu_lo ? {cpu_byte_c[7:4], cpu_wdata} : {cpu_wdata, cpu_byte_c[3:0]};
        end else if (byte_we) begin
            we_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_d) begin
            mem_q[waddr_d] <= wdata_d;
        end
    end

endmodule

// File: rtl/moonbase_ext_bus.sv
// CPU external bus: address latch, nibble-serial RAM/device access, input sync and program loader.
// MOONBASE_SPLIT_SPACE_EN adds the code/data space bit to RAM addressing.
module moonbase_ext_bus
    import moonbase_pkg::*;
#(
    parameter int unsigned N_DEV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    moonbase_ext_bus_if.slave    bus,
    input  logic [2*N_DEV-1:0]   dev_in,
    output logic [8*N_DEV-1:0]   dev_out
);

    localparam int unsigned IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    bus_data_t             fields_c;
    logic                  strobe_c;
    logic                  data_cyc_c;
    logic                  ram_we_c;
    logic                  dev_we_c;
    logic                  load_ready_c;
    logic                  load_we_c;
    logic [IDX_W-1:0]      dev_idx_c;
    logic [MEM_AW-1:0]     cpu_addr_c;
    logic [MEM_AW-1:0]     load_addr_c;
    logic [3:0]            ram_rd_c;

    logic [ADDR_W-1:0]     latch_q, latch_d;
    logic                  nib_q, nib_d;
    logic [N_DEV-1:0][7:0] dev_reg_q, dev_reg_d;
    logic [N_DEV-1:0][1:0] sync1_q, sync1_d;
    logic [N_DEV-1:0][1:0] sync2_q, sync2_d;

    assign fields_c   = decode_data(bus.bus_out);
    assign strobe_c   = bus.bus_out[STROBE];
    assign data_cyc_c = ~strobe_c;
    assign dev_idx_c  = latch_q[IDX_W-1:0];

    // Writes are dropped while reset is high so a mid-write reset cannot commit
    assign ram_we_c     = data_cyc_c & ~fields_c.ram_wr_n & ~reset;
    assign dev_we_c     = data_cyc_c & ~fields_c.dev_wr_n & ~reset;
    assign load_ready_c = ~reset & ~(data_cyc_c & ~fields_c.ram_wr_n);
    assign load_we_c    = bus.load_valid & load_ready_c;

`ifdef MOONBASE_SPLIT_SPACE_EN
    assign cpu_addr_c  = {fields_c.code_sel, latch_q};
    assign load_addr_c = bus.load_addr;
`else
    logic unused_space;
    assign cpu_addr_c   = latch_q;
    assign load_addr_c  = bus.load_addr[ADDR_W-1:0];
    assign unused_space = fields_c.code_sel ^ bus.load_addr[7];
`endif

    // Strobe reloads the latch and restarts at the high nibble; data cycles alternate nibbles
    always_comb begin
        latch_d = latch_q;
        nib_d   = nib_q;
        if (strobe_c) begin
            latch_d = bus.bus_out[ADDR_W-1:0];
            nib_d   = 1'b0;
        end else begin
            nib_d = ~nib_q;
        end
    end

    always_comb begin
        dev_reg_d = dev_reg_q;
        if (dev_we_c) begin
            if (nib_q) begin
                dev_reg_d[dev_idx_c][3:0] = fields_c.nibble;
            end else begin
                dev_reg_d[dev_idx_c][7:4] = fields_c.nibble;
            end
        end
    end

    always_comb begin
        sync1_d = dev_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_q   <= '0;
            nib_q     <= 1'b0;
            dev_reg_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            latch_q   <= latch_d;
            nib_q     <= nib_d;
            dev_reg_q <= dev_reg_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    moonbase_nibble_ram u_ram (
        .clk         (clk),
        .cpu_we      (ram_we_c),
        .cpu_addr    (cpu_addr_c),
        .cpu_lo      (nib_q),
        .cpu_wdata   (fields_c.nibble),
        .cpu_rdata_c (ram_rd_c),
        .byte_we     (load_we_c),
        .byte_addr   (load_addr_c),
        .byte_wdata  (bus.load_data)
    );

    assign bus.ram_data   = ram_rd_c;
    assign bus.dev_data   = sync2_q[dev_idx_c];
    assign bus.load_ready = load_ready_c;
    assign dev_out        = dev_reg_q;

endmodule

// File: doc/moonbase_ext_bus.md
MOONBASE_EXT_BUS -- requirements
Module: moonbase_ext_bus

Interface
REQ-001 Parameter N_DEV, default 4: number of 8-bit device output registers and 2-bit device inputs; power of two, 2..4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state listed under Reset.
REQ-004 bus_out  input  8  CPU output bus: [7]=strobe; strobe=1: [6:0]=address; strobe=0: [6]=code_sel, [5]=ram_wr_n, [4]=dev_wr_n, [3:0]=write nibble.
REQ-005 ram_data  output  4  read nibble returned to the CPU (CPU io_in[5:2]).
REQ-006 dev_data  output  2  device read bits returned to the CPU (CPU io_in[7:6]).
REQ-007 dev_in  input  2*N_DEV  asynchronous device inputs, 2 bits per device.
REQ-008 dev_out  output  8*N_DEV  device output registers, concatenated, device 0 in the LSBs.
REQ-009 load_valid  input  1  program-loader byte valid.
REQ-010 load_ready  output  1  loader byte accepted this cycle when high with load_valid.
REQ-011 load_addr  input  8  loader byte address; [7] is the space select (1=code).
REQ-012 load_data  input  8  loader byte.

Function
REQ-013 Strobe cycle (bus_out[7]=1): latch <= bus_out[6:0]; nib <= 0 (high nibble next); no write occurs.
REQ-014 Data cycle (bus_out[7]=0): nib toggles each cycle (0->1->0, wrapping); latch holds.
REQ-015 Effective address = {space, latch}; space = bus_out[6] during data cycles.
REQ-016 ram_data is combinational: mem[addr][7:4] when nib=0, mem[addr][3:0] when nib=1; zero-latency, same cycle.
REQ-017 RAM write: data cycle with ram_wr_n=0 writes bus_out[3:0] into the nibble selected by nib at the rising edge; the other nibble is unchanged.
REQ-018 Device write: data cycle with dev_wr_n=0 writes bus_out[3:0] into the nib-selected nibble of dev_reg[latch[log2(N_DEV)-1:0]]; ram_wr_n=0 and dev_wr_n=0 together perform both writes.
REQ-019 dev_in passes through a 2-flop synchroniser; dev_data = sync[latch index], 2-cycle input latency.
REQ-020 load_ready = !reset && !(data cycle && ram_wr_n=0); on load_valid && load_ready the whole byte mem[load_addr] <= load_data.
REQ-021 The CPU write has priority over the loader; a stalled load holds load_addr and load_data until accepted.
REQ-022 Loader and CPU access the same storage; a loaded byte is readable on the cycle after acceptance.
REQ-023 Device writes never stall the loader.

Reset
REQ-024 Asynchronous reset: latch=0, nib=0, every dev_reg=0 (dev_out=0), synchroniser flops=0; memory contents are not reset.
REQ-025 A reset asserted mid-write suppresses that write; after release the first data cycle selects the high nibble.

Configuration
REQ-026 Macro MOONBASE_SPLIT_SPACE_EN defined: 256-byte storage, space bit taken from bus_out[6] / load_addr[7] (128 code + 128 data bytes).
REQ-027 Macro undefined: 128-byte storage, bus_out[6] and load_addr[7] ignored; code and data alias.

Structure
REQ-028 Package moonbase_pkg holds the bus bit positions (STROBE, CODE_SEL, RAM_WR_N, DEV_WR_N), address width 7, and memory depth constants.
REQ-029 Sub-module moonbase_nibble_ram: byte storage with one nibble-write port, one byte-write port and one combinational nibble read port.

Verification
REQ-030 Load byte 0xA5 at load_addr 0x83; strobe 0x03, then two data cycles with bus_out[6]=1 -> ram_data 0xA then 0x5.
REQ-031 Strobe 0x10; data cycles with ram_wr_n=0 and nibbles 0x3, 0xC; re-strobe 0x10 and read -> 0x3 then 0xC; the neighbouring byte is unchanged.
REQ-032 With load_valid=1 during a CPU RAM write cycle -> load_ready=0; the byte is accepted on the next non-write cycle; the CPU data is intact.
REQ-033 Strobe 0x02; dev_wr_n=0 with nibbles 0x7, 0xE -> dev_out[23:16]=0x7E; dev_in[5:4]=2'b10 -> dev_data=2'b10 two cycles later.
REQ-034 Assert reset mid-write (after the high nibble) -> dev_out=0, the low nibble is not written, and the next data cycle reads the high nibble.
REQ-035 With MOONBASE_SPLIT_SPACE_EN undefined, load 0x5A at 0x04 and read at latch 0x04 with bus_out[6]=0 -> 0x5, 0xA (alias).
